// File: rtl/axi_master_rd.sv
// axi_master_rd: AXI4 read-channel master issuing a single INCR burst per
// rd_start and forwarding every accepted beat straight to the user side.
// The beat counter alone decides when the burst ends; rlast is only checked.
//
// Optional feature macro: AXI_RD_RESP_CHECK_EN
//   defined   -> rd_err is a sticky flag for bad rresp / misplaced rlast
//   undefined -> rd_err is tied low and no checking logic is built
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for rd_start, rd_ready high
// RA_WAIT  | capture rd_addr / rd_len into the AR registers
// RA       | arvalid high, waiting for arready
// R_WAIT   | address accepted, clear the beat counter
// R        | rready high, accepting beats until cnt reaches arlen

module axi_master_rd #(
    parameter logic [3:0] M_AXI_ARID    = 4'd0,
    parameter logic [2:0] M_AXI_ARSIZE  = 3'b011,
    parameter logic [1:0] M_AXI_ARBURST = 2'b01,
    parameter logic       M_AXI_ARLOCK  = 1'b0,
    parameter logic [3:0] M_AXI_ARCACHE = 4'b0010,
    parameter logic [2:0] M_AXI_ARPROT  = 3'b000,
    parameter logic [3:0] M_AXI_ARQOS   = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        rd_start,
    input  logic [29:0] rd_addr,
    input  logic [7:0]  rd_len,
    output logic [63:0] rd_data,
    output logic        m_axi_r_handshake,
    output logic        rd_done,
    output logic        rd_ready,
    output logic        rd_err,

    output logic [3:0]  m_axi_arid,
    output logic [29:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arlock,
    output logic [3:0]  m_axi_arcache,
    output logic [2:0]  m_axi_arprot,
    output logic [3:0]  m_axi_arqos,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [3:0]  m_axi_rid,
    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RA_WAIT = 3'd1,
        S_RA      = 3'd2,
        S_R_WAIT  = 3'd3,
        S_R       = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        rd_done_q, rd_done_d;
    logic        rd_ready_q, rd_ready_d;

    logic        ar_hs;
    logic        r_hs;
    logic        last_beat;

    // The read ID is not used: only one burst is ever outstanding.
    logic        unused_rid;
    assign unused_rid = ^m_axi_rid;

    // Constant AR attributes come straight from the parameters.
    assign m_axi_arid    = M_AXI_ARID;
    assign m_axi_arsize  = M_AXI_ARSIZE;
    assign m_axi_arburst = M_AXI_ARBURST;
    assign m_axi_arlock  = M_AXI_ARLOCK;
    assign m_axi_arcache = M_AXI_ARCACHE;
    assign m_axi_arprot  = M_AXI_ARPROT;
    assign m_axi_arqos   = M_AXI_ARQOS;

    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign rd_done       = rd_done_q;
    assign rd_ready      = rd_ready_q;

    // Beat data and strobe go to the user with no added latency.
    assign ar_hs             = arvalid_q & m_axi_arready;
    assign r_hs              = m_axi_rvalid & rready_q;
    assign last_beat         = (cnt_q == arlen_q);
    assign rd_data           = m_axi_rdata;
    assign m_axi_r_handshake = r_hs;

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        cnt_d     = cnt_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rd_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_start) begin
                    state_d = S_RA_WAIT;
                end
            end
            S_RA_WAIT: begin
                araddr_d  = rd_addr;
                arlen_d   = rd_len;
                arvalid_d = 1'b1;
                state_d   = S_RA;
            end
            S_RA: begin
                // arvalid holds until accepted regardless of arready behaviour.
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R_WAIT;
                end
            end
            S_R_WAIT: begin
                cnt_d    = 8'd0;
                rready_d = 1'b1;
                state_d  = S_R;
            end
            S_R: begin
                if (r_hs) begin
                    // Saturate so a 256-beat burst never wraps back to zero.
                    if (cnt_q < arlen_q) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (last_beat) begin
                        rready_d  = 1'b0;
                        rd_done_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    assign rd_ready_d = (state_d == S_IDLE);

    // Sequencer registers; an asynchronous reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            araddr_q   <= 30'd0;
            arlen_q    <= 8'd0;
            cnt_q      <= 8'd0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            cnt_q      <= cnt_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rd_done_q  <= rd_done_d;
            rd_ready_q <= rd_ready_d;
        end
    end

`ifdef AXI_RD_RESP_CHECK_EN
    logic rd_err_q, rd_err_d;

    // Sticky error: cleared when a new burst is captured, set by any beat
    // with a non-OKAY response or an rlast that disagrees with the counter.
    always_comb begin
        rd_err_d = rd_err_q;
        if (state_q == S_RA_WAIT) begin
            rd_err_d = 1'b0;
        end else if ((state_q == S_R) && r_hs) begin
            if ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat)) begin
                rd_err_d = 1'b1;
            end
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end

    assign rd_err = rd_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{m_axi_rresp, m_axi_rlast};
    assign rd_err      = 1'b0;
`endif

endmodule

// File: tb/tb_axi_master_rd.sv
// Directed bench for axi_master_rd: the bench plays the AXI slave, pushes the
// data of every beat it presents into a scoreboard queue and pops it when the
// user strobe fires.

module tb_axi_master_rd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_start;
    logic [29:0] rd_addr;
    logic [7:0]  rd_len;
    logic [63:0] rd_data;
    logic        m_axi_r_handshake;
    logic        rd_done;
    logic        rd_ready;
    logic        rd_err;
    logic [3:0]  m_axi_arid;
    logic [29:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [3:0]  m_axi_rid;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          done_total = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rd_done === 1'b1) done_total++;

    axi_master_rd dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rd_start          (rd_start),
        .rd_addr           (rd_addr),
        .rd_len            (rd_len),
        .rd_data           (rd_data),
        .m_axi_r_handshake (m_axi_r_handshake),
        .rd_done           (rd_done),
        .rd_ready          (rd_ready),
        .rd_err            (rd_err),
        .m_axi_arid        (m_axi_arid),
        .m_axi_araddr      (m_axi_araddr),
        .m_axi_arlen       (m_axi_arlen),
        .m_axi_arsize      (m_axi_arsize),
        .m_axi_arburst     (m_axi_arburst),
        .m_axi_arlock      (m_axi_arlock),
        .m_axi_arcache     (m_axi_arcache),
        .m_axi_arprot      (m_axi_arprot),
        .m_axi_arqos       (m_axi_arqos),
        .m_axi_arvalid     (m_axi_arvalid),
        .m_axi_arready     (m_axi_arready),
        .m_axi_rid         (m_axi_rid),
        .m_axi_rdata       (m_axi_rdata),
        .m_axi_rresp       (m_axi_rresp),
        .m_axi_rlast       (m_axi_rlast),
        .m_axi_rvalid      (m_axi_rvalid),
        .m_axi_rready      (m_axi_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_data(input logic [29:0] a, input int k);
        return {2'b00, a, 32'(k)};
    endfunction

    // One complete burst seen from the slave side. pre_started means the
    // previous call already issued rd_start (back-to-back case); b2b makes
    // this call issue the next rd_start in its rd_done cycle.
    task automatic run_burst(input logic [29:0] addr, input int n, input int ar_stall,
                             input bit toggle, input int bad_resp_beat, input int rlast_beat,
                             input bit err_if_checked, input bit pre_started,
                             input bit b2b, input logic [29:0] nxt_addr, input int nxt_len);
        int  k;
        int  strobes;
        int  idle;
        int  ar_hi;
        int  ts;
        bit  hs;
        bit  ph;
        bit  pushed;
        bit  exp_err;
`ifdef AXI_RD_RESP_CHECK_EN
        exp_err = err_if_checked;
`else
        exp_err = 1'b0;
`endif
        if (!pre_started) begin
            t0       = cyc;
            rd_start = 1'b1;
            rd_addr  = addr;
            rd_len   = 8'(n);
            tick();
        end
        ts            = t0;
        rd_start      = 1'b0;
        m_axi_arready = (ar_stall == 0);
        @(negedge clk);
        chk("arvalid_in_ra_wait", 64'(m_axi_arvalid), 64'(0));
        tick();
        rd_addr = ~addr;
        rd_len  = ~8'(n);

        ar_hi = 0;
        hs    = 1'b0;
        for (int lim = 0; lim < 50 && !hs; lim++) begin
            @(negedge clk);
            if (m_axi_arvalid === 1'b1) begin
                ar_hi++;
                if (ar_hi == 1) begin
                    chk("arvalid_first_cycle", 64'(cyc - ts), 64'(2));
                    chk("rd_err_cleared", 64'(rd_err), 64'(0));
                end
                chk("araddr", 64'(m_axi_araddr), 64'(addr));
                chk("arlen", 64'(m_axi_arlen), 64'(n));
            end
            hs = (m_axi_arvalid === 1'b1) && (m_axi_arready === 1'b1);
            tick();
            if (!hs) m_axi_arready = (ar_hi >= ar_stall);
        end
        chk("ar_handshake_seen", 64'(hs), 64'(1));
        chk("arvalid_high_cycles", 64'(ar_hi), 64'(ar_stall + 1));
        m_axi_arready = 1'b0;
        @(negedge clk);
        chk("r_wait_arvalid", 64'(m_axi_arvalid), 64'(0));
        chk("r_wait_rready", 64'(m_axi_rready), 64'(0));
        tick();

        k       = 0;
        strobes = 0;
        idle    = 0;
        ph      = 1'b1;
        pushed  = 1'b0;
        for (int lim = 0; lim < 2000 && k <= n; lim++) begin
            m_axi_rvalid = toggle ? ph : 1'b1;
            m_axi_rdata  = beat_data(addr, k);
            m_axi_rresp  = (k == bad_resp_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = (rlast_beat >= 0) ? (k == rlast_beat) : (k == n);
            if (m_axi_rvalid && !pushed) begin
                exp_q.push_back(beat_data(addr, k));
                pushed = 1'b1;
            end
            if (!m_axi_rvalid) idle++;
            @(negedge clk);
            if (m_axi_r_handshake === 1'b1) begin
                strobes++;
                if (exp_q.size() == 0) chk("scoreboard_underflow", 64'(1), 64'(0));
                else chk("rd_data", rd_data, exp_q.pop_front());
                if (n == 0) chk("single_strobe_cycle", 64'(cyc - ts), 64'(4));
                k++;
                pushed = 1'b0;
            end
            if (toggle) ph = !ph;
            tick();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        if (b2b) begin
            t0       = cyc;
            rd_start = 1'b1;
            rd_addr  = nxt_addr;
            rd_len   = 8'(nxt_len);
        end
        @(negedge clk);
        chk("rd_done_pulse", 64'(rd_done), 64'(1));
        chk("rready_after_last", 64'(m_axi_rready), 64'(0));
        chk("rd_ready_at_done", 64'(rd_ready), 64'(1));
        chk("rd_err_at_done", 64'(rd_err), 64'(exp_err));
        chk("strobe_count", 64'(strobes), 64'(n + 1));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        chk("done_latency", 64'(cyc - ts), 64'(5 + n + ar_stall + idle));
        tick();
        if (!b2b) begin
            @(negedge clk);
            chk("rd_done_single", 64'(rd_done), 64'(0));
        end
    endtask

    initial begin
        int strobes;
        int d0;
        rst_n         = 1'b0;
        rd_start      = 1'b0;
        rd_addr       = '0;
        rd_len        = '0;
        m_axi_arready = 1'b0;
        m_axi_rid     = 4'd0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_rd_ready", 64'(rd_ready), 64'(1));
        chk("reset_arvalid", 64'(m_axi_arvalid), 64'(0));
        chk("reset_rready", 64'(m_axi_rready), 64'(0));
        chk("reset_rd_done", 64'(rd_done), 64'(0));
        chk("reset_rd_err", 64'(rd_err), 64'(0));
        chk("reset_araddr", 64'(m_axi_araddr), 64'(0));
        chk("reset_arlen", 64'(m_axi_arlen), 64'(0));
        chk("const_ar_fields", 64'({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                                    m_axi_arcache, m_axi_arprot, m_axi_arqos}),
            64'({4'd0, 3'b011, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000}));
        rst_n = 1'b1;
        tick();
        @(negedge clk);

        // single beat, no stalls
        run_burst(30'h100, 0, 0, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, '0, 0);
        // 8 beats, rvalid toggling, data 0..7
        run_burst(30'h0, 7, 0, 1'b1, -1, -1, 1'b0, 1'b0, 1'b0, '0, 0);
        // arready held low for 3 cycles
        run_burst(30'h3ABC, 3, 3, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, '0, 0);
        // 256 beats, then back-to-back start in the rd_done cycle
        run_burst(30'h40, 255, 0, 1'b0, -1, -1, 1'b0, 1'b0, 1'b1, 30'h55, 2);
        run_burst(30'h55, 2, 0, 1'b0, -1, -1, 1'b0, 1'b1, 1'b0, '0, 0);
        // error reporting: bad rresp, early rlast, each followed by a clean burst
        run_burst(30'h80, 7, 0, 1'b0, 2, -1, 1'b1, 1'b0, 1'b0, '0, 0);
        run_burst(30'h90, 1, 0, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, '0, 0);
        run_burst(30'hA0, 7, 0, 1'b0, -1, 3, 1'b1, 1'b0, 1'b0, '0, 0);
        run_burst(30'hB0, 0, 0, 1'b0, -1, -1, 1'b0, 1'b0, 1'b0, '0, 0);

        // reset in R after beat 3 of an 8-beat burst
        rd_start      = 1'b1;
        rd_addr       = 30'h2000;
        rd_len        = 8'd7;
        m_axi_arready = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (3) tick();
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b1;
        strobes       = 0;
        for (int lim = 0; lim < 50 && strobes < 4; lim++) begin
            m_axi_rdata = 64'(strobes);
            @(negedge clk);
            if (m_axi_r_handshake === 1'b1) strobes++;
            tick();
        end
        chk("reset_test_beats", 64'(strobes), 64'(4));
        d0           = done_total;
        rst_n        = 1'b0;
        m_axi_rvalid = 1'b0;
        #1;
        chk("midreset_rready", 64'(m_axi_rready), 64'(0));
        chk("midreset_rd_ready", 64'(rd_ready), 64'(1));
        chk("midreset_rd_done", 64'(rd_done), 64'(0));
        chk("midreset_araddr", 64'(m_axi_araddr), 64'(0));
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("midreset_no_done", 64'(done_total), 64'(d0));
        chk("midreset_idle_ready", 64'(rd_ready), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
